// File: rtl/edge_burst_gen_if.sv
// Request/response bundle for the edge burst generator: burst parameters in,
// generated line and status out.
interface edge_burst_gen_if #(
   parameter int CNT_W = 3
);
   logic             start;
   logic [CNT_W-1:0] num_edges;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [CNT_W-1:0] window;
   logic             signal;
   logic             busy;
   logic             done;
   logic             overrun;

   modport master (
      output start, num_edges, high_len, low_len, window,
      input  signal, busy, done, overrun
   );

   modport slave (
      input  start, num_edges, high_len, low_len, window,
      output signal, busy, done, overrun
   );
endinterface

// File: rtl/edge_burst_gen.sv
// Drives a line with a programmed burst of rising edges, stretched to cover a
// minimum busy window; flags bursts that overflow the window.
module edge_burst_gen #(
   parameter int CNT_W = 3
) (
   input logic              clk,
   input logic              reset,
   edge_burst_gen_if.slave  bus
);

   localparam int WIN_W = CNT_W + 4;

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_TAIL} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_edge_cnt;
   logic [CNT_W-1:0] r_phase_cnt;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] r_low;
   logic [CNT_W-1:0] r_window;
   logic             r_signal;
   logic             r_busy;
   logic             r_done;
   logic             r_overrun;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_edge_nxt;
   logic [CNT_W-1:0] w_phase_nxt;
   logic [WIN_W-1:0] w_win_nxt;
   logic             w_accept;
   logic             w_noop;
   logic             w_finish;
   logic             w_win_covered;
   logic             w_signal_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_overrun_nxt;

   function automatic logic [WIN_W-1:0] sat_inc(input logic [WIN_W-1:0] v);
      return (&v) ? v : v + WIN_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] norm_len(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   assign w_win_covered = (r_win_cnt >= WIN_W'(r_window));

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_edge_cnt  <= '0;
         r_phase_cnt <= '0;
         r_win_cnt   <= '0;
         r_signal    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_edge_cnt  <= w_edge_nxt;
         r_phase_cnt <= w_phase_nxt;
         r_win_cnt   <= w_win_nxt;
         r_signal    <= w_signal_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_overrun   <= w_overrun_nxt;
      end
   end

   // Burst parameters are frozen at acceptance so mid-burst input changes are harmless
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_num    <= bus.num_edges;
         r_high   <= norm_len(bus.high_len);
         r_low    <= norm_len(bus.low_len);
         r_window <= bus.window;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_edge_nxt  = r_edge_cnt;
      w_phase_nxt = r_phase_cnt;
      w_win_nxt   = r_win_cnt;
      w_accept    = 1'b0;
      w_noop      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.num_edges != '0) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_HIGH;
                  w_edge_nxt  = CNT_W'(1);
                  w_phase_nxt = CNT_W'(1);
                  w_win_nxt   = WIN_W'(1);
               end else begin
                  w_noop = 1'b1;
               end
            end
         end
         S_HIGH: begin
            if (r_phase_cnt < r_high) begin
               w_phase_nxt = r_phase_cnt + CNT_W'(1);
               w_win_nxt   = sat_inc(r_win_cnt);
            end else if (r_edge_cnt < r_num) begin
               w_state_nxt = S_LOW;
               w_phase_nxt = CNT_W'(1);
               w_win_nxt   = sat_inc(r_win_cnt);
            end else if (w_win_covered) begin
               w_state_nxt = S_IDLE;
               w_finish    = 1'b1;
            end else begin
               w_state_nxt = S_TAIL;
               w_win_nxt   = sat_inc(r_win_cnt);
            end
         end
         S_LOW: begin
            w_win_nxt = sat_inc(r_win_cnt);
            if (r_phase_cnt < r_low) begin
               w_phase_nxt = r_phase_cnt + CNT_W'(1);
            end else begin
               w_state_nxt = S_HIGH;
               w_edge_nxt  = r_edge_cnt + CNT_W'(1);
               w_phase_nxt = CNT_W'(1);
            end
         end
         S_TAIL: begin
            if (w_win_covered) begin
               w_state_nxt = S_IDLE;
               w_finish    = 1'b1;
            end else begin
               w_win_nxt = sat_inc(r_win_cnt);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_signal_nxt  = (w_state_nxt == S_HIGH);
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_done_nxt    = w_finish | w_noop;
      w_overrun_nxt = r_overrun;
      if (w_accept || w_noop) begin
         w_overrun_nxt = 1'b0;
      end else if ((r_state == S_HIGH || r_state == S_LOW) && !w_finish &&
                   (r_window != '0) && w_win_covered) begin
         w_overrun_nxt = 1'b1;
      end
   end

   assign bus.signal  = r_signal;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.overrun = r_overrun;

endmodule

// File: doc/edge_burst_gen.md
# edge_burst_gen

Stimulus generator that drives a single-bit line with a programmed burst of rising edges inside a minimum clock window. It is the driving end of the edge-count window protocol. The edge-count checker on the receive side watches a line for rising edges within a short clock window. This block produces exactly that waveform, both for on-chip self-test and for generating handshake pulses toward peer blocks. All outputs are registered.

## Interface
- CNT_W, 3, width of num_edges, high_len, low_len and window. Internal window counter is CNT_W+4 bits and saturating.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  request a burst; sampled only in IDLE
- num_edges  in  CNT_W  rising edges to produce; 0 = no-op
- high_len  in  CNT_W  cycles high per pulse; 0 treated as 1
- low_len  in  CNT_W  cycles low between pulses; 0 treated as 1
- window  in  CNT_W  minimum busy length in cycles; 0 or 1 = no tail
- signal  out  1  generated line
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse
- overrun  out  1  sticky; burst did not fit in window

## Operation
- States: IDLE, HIGH, LOW, TAIL.
- Reset (async): state=IDLE; signal, busy, done and overrun = 0; all counters = 0.
- Counters:
  - edge_cnt: edges emitted so far.
  - phase_cnt: cycles spent in the current HIGH or LOW phase.
  - win_cnt: cycles busy, including the current cycle.
- IDLE with start=1 and num_edges≠0:
  - Capture num_edges, high_len and low_len (0→1), and window.
  - Go to HIGH with signal=1, busy=1, edge_cnt=1, phase_cnt=1, win_cnt=1.
  - Clear overrun.
- IDLE with start=1 and num_edges=0: done=1 for the next cycle only. busy and signal stay 0. overrun is cleared.
- HIGH while phase_cnt<high_len: phase_cnt+1.
- HIGH when phase_cnt==high_len:
  - If edge_cnt<num_edges: go to LOW with signal=0 and phase_cnt=1.
  - Else, if win_cnt≥window: go to IDLE with signal=0, busy=0, done=1.
  - Else: go to TAIL with signal=0.
- LOW while phase_cnt<low_len: phase_cnt+1.
- LOW when phase_cnt==low_len: go to HIGH with signal=1, edge_cnt+1, phase_cnt=1.
- TAIL: signal=0.
  - If win_cnt≥window: go to IDLE with busy=0, done=1.
  - Else: win_cnt+1.
- win_cnt increments on every clock edge on which the block stays busy. It saturates at its all-ones value and never wraps.
- overrun: set on any edge where all of the following hold:
  - state is HIGH or LOW;
  - the burst is not finishing on that edge;
  - window≥1 and win_cnt≥window.
  - Once set, overrun stays 1 until the next accepted start or reset.
- start while busy=1 is ignored. Captured parameters are unaffected by input changes mid-burst.
- done is high for exactly one cycle per accepted start, and never while busy=1.

## Timing
- Start latency: start sampled at edge E0 gives signal=1 and busy=1 from E0 onward (first cycle c1).
- Each pulse is high for exactly high_len cycles. Consecutive pulses are separated by exactly low_len low cycles.
- The last pulse is followed by TAIL only if the window is not yet covered.
- Busy duration = max(window, num_edges·high_len + (num_edges−1)·low_len) cycles. That is the total burst length, or the window if longer.
- done and busy=0 appear in the same cycle, immediately after the last busy cycle.
- Back-to-back: start may be asserted in the done cycle. It is accepted, so the next burst begins one cycle later.
- Reset mid-burst: outputs go to 0 immediately. There is no done pulse, and a new start is accepted on the first edge after reset is released.

## Test plan
- Burst fits window exactly:
  - Stimulus: num_edges=3, high=1, low=1, window=5, start at E0.
  - Required: signal 1,0,1,0,1 over c1–c5; done=1 and busy=0 at c6; overrun=0. The receive-side checker sees 3 edges in its 5-clock window.
- Tail padding:
  - Stimulus: num_edges=1, high=1, low=1, window=4.
  - Required: signal=1 at c1 only; busy over c1–c4; done at c5.
- Overrun:
  - Stimulus: num_edges=3, high=2, low=2, window=5.
  - Required: signal high at c1–2, c5–6 and c9–10; overrun=1 from c6; done at c11; overrun stays 1 until the next start.
- No-op and zero-length fields:
  - Stimulus: num_edges=0 → Required: done at c1 only, signal and busy stay 0.
  - Stimulus: high_len=0, low_len=0, num_edges=2, window=0 → Required: signal 1,0,1 over c1–c3; done at c4.
- start while busy: pulse start at c2 during a 3-edge burst → no effect on waveform or timing. A start in the done cycle is accepted.
- Reset mid-burst: assert reset at c3 of a 3-edge burst → signal, busy, done and overrun go to 0 asynchronously; a new burst after release runs normally from c1.
